pe_stream_driver: RTL and testbench

- Host-side transmitter/collector for a 2-input, 1-output PE wrapper that uses the VALID/BP stream protocol.
- Splits an interleaved host operand stream (a0,b0,a1,b1,...) onto the PE's D (even words) and D2 (odd words) channels, honouring D_BP/D2_BP.
- Gathers PE results from Q/Q_VALID into a host-facing ready/valid stream, driving Q_BP.
- A START/LEN job interface counts N operand pairs in and N results out, then pulses DONE.

---
 rtl/pe_stream_pkg.sv | 15 +
 rtl/pe_stream_driver_if.sv | 48 ++++
 rtl/pe_sync_fifo.sv | 69 ++++++
 rtl/pe_stream_driver.sv | 155 +++++++++++++++
 tb/tb_pe_stream_driver.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_stream_pkg.sv
// Shared types and constants for the PE stream driver.
//   DATA_W  : width of operand and result words
//   state_e : job FSM state encoding
package pe_stream_pkg;

  localparam int unsigned DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/pe_stream_driver_if.sv
// Bundle of the job, host-operand, PE-channel and host-result signals.
//   master : driver side (pe_stream_driver)
//   slave  : environment side (host + PE wrapper)
interface pe_stream_driver_if
  import pe_stream_pkg::*;
#(
  parameter int unsigned LEN_W = 32
);
  // job control
  logic              START;
  logic [LEN_W-1:0]  LEN;
  logic              BUSY;
  logic              DONE;
  logic              ERR_Q2;
  // host operand stream
  logic [DATA_W-1:0] H_D;
  logic              H_VALID;
  logic              H_READY;
  // PE input channels
  logic [DATA_W-1:0] D;
  logic              D_VALID;
  logic              D_BP;
  logic [DATA_W-1:0] D2;
  logic              D2_VALID;
  logic              D2_BP;
  // PE result channels
  logic [DATA_W-1:0] Q;
  logic              Q_VALID;
  logic              Q_BP;
  logic [DATA_W-1:0] Q2;
  logic              Q2_VALID;
  logic              Q2_BP;
  // host result stream
  logic [DATA_W-1:0] R_D;
  logic              R_VALID;
  logic              R_READY;

  modport master (
    input  START, LEN, H_D, H_VALID, D_BP, D2_BP, Q, Q_VALID, Q2, Q2_VALID, R_READY,
    output BUSY, DONE, ERR_Q2, H_READY, D, D_VALID, D2, D2_VALID, Q_BP, Q2_BP, R_D, R_VALID
  );

  modport slave (
    output START, LEN, H_D, H_VALID, D_BP, D2_BP, Q, Q_VALID, Q2, Q2_VALID, R_READY,
    input  BUSY, DONE, ERR_Q2, H_READY, D, D_VALID, D2, D2_VALID, Q_BP, Q2_BP, R_D, R_VALID
  );

endinterface

// File: rtl/pe_sync_fifo.sv
// Synchronous FIFO with occupancy count; writes when full and reads when
// empty are ignored.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   wr_en_i / wr_data_i   : push
//   rd_en_i / rd_data_o   : pop; rd_data_o shows the head continuously
//   count_o, full_o, empty_o : registered occupancy status
module pe_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic [WIDTH-1:0]        wr_data_i,
  input  logic                    rd_en_i,
  output logic [WIDTH-1:0]        rd_data_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_fire, rd_fire;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign wr_fire   = wr_en_i & ~full_o;
  assign rd_fire   = rd_en_i & ~empty_o;

  // Pointer and occupancy update; pointers wrap naturally (power-of-two depth).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only visible through the pointers.
  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/pe_stream_driver.sv
// Host-side driver for a 2-input/1-output PE: splits the interleaved host
// operand stream onto D (even words) / D2 (odd words), buffers PE results
// into a host ready/valid stream, and runs START/LEN jobs ending in DONE.
//   CLK, SYS_RST : clock, synchronous active-high reset
//   bus          : job, host-operand, PE-channel and host-result signals
module pe_stream_driver
  import pe_stream_pkg::*;
#(
  parameter int unsigned LEN_W       = 32,
  parameter int unsigned OFIFO_DEPTH = 4
) (
  input logic                CLK,
  input logic                SYS_RST,
  pe_stream_driver_if.master bus
);

  localparam int unsigned CNT_W  = LEN_W + 1;
  localparam int unsigned FCNT_W = $clog2(OFIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  n_q, n_d;
  logic [LEN_W-1:0]  res_q, res_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  sent_q, sent_d;
  logic [DATA_W-1:0] hold_w_q, hold_w_d;
  logic              hold_v_q, hold_v_d;
  logic              hold_ch_q, hold_ch_d;
  logic              chan_q, chan_d;
  logic              err_q, err_d;

  logic [CNT_W-1:0]  words_c;
  logic              hold_bp, send, h_ready, h_acc;
  logic              active, r_fire, res_fire;
  logic [FCNT_W-1:0] fifo_cnt;
  logic              fifo_empty;
  logic              unused_fifo_full;
  logic              unused_q2;

  // Q2 data is discarded; only its valid is monitored.
  assign unused_q2 = ^bus.Q2;

  // Operand handshake: the hold slot frees up in the same cycle it drains.
  assign words_c  = {n_q, 1'b0};
  assign hold_bp  = hold_ch_q ? bus.D2_BP : bus.D_BP;
  assign send     = hold_v_q & ~hold_bp;
  assign h_ready  = (state_q == RUN) & (acc_q < words_c) & (~hold_v_q | send);
  assign h_acc    = bus.H_VALID & h_ready;

  // Only reads during a job count towards its N results.
  assign active   = (state_q == RUN) | (state_q == DRAIN);
  assign r_fire   = ~fifo_empty & bus.R_READY;
  assign res_fire = r_fire & active;

  pe_sync_fifo #(
    .DEPTH (OFIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_ofifo (
    .clk_i     (CLK),
    .rst_i     (SYS_RST),
    .wr_en_i   (bus.Q_VALID),
    .wr_data_i (bus.Q),
    .rd_en_i   (bus.R_READY),
    .rd_data_o (bus.R_D),
    .count_o   (fifo_cnt),
    .full_o    (unused_fifo_full),
    .empty_o   (fifo_empty)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    res_d     = res_q;
    acc_d     = acc_q;
    sent_d    = sent_q;
    hold_w_d  = hold_w_q;
    hold_ch_d = hold_ch_q;
    chan_d    = chan_q;
    hold_v_d  = h_acc | (hold_v_q & ~send);
    err_d     = err_q | bus.Q2_VALID;

    if (h_acc) begin
      hold_w_d  = bus.H_D;
      hold_ch_d = chan_q;
      chan_d    = ~chan_q;
      acc_d     = acc_q + CNT_W'(1);
    end
    if (send)     sent_d = sent_q + CNT_W'(1);
    if (res_fire) res_d  = res_q + LEN_W'(1);

    unique case (state_q)
      IDLE: begin
        if (bus.START) begin
          n_d     = bus.LEN;
          res_d   = '0;
          acc_d   = '0;
          sent_d  = '0;
          chan_d  = 1'b0;
          err_d   = 1'b0;
          state_d = (bus.LEN != '0) ? RUN : FIN;
        end
      end
      RUN: begin
        if (sent_d == words_c) state_d = DRAIN;
      end
      DRAIN: begin
        if (res_d >= n_q) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (SYS_RST) begin
      state_q   <= IDLE;
      n_q       <= '0;
      res_q     <= '0;
      acc_q     <= '0;
      sent_q    <= '0;
      hold_w_q  <= '0;
      hold_v_q  <= 1'b0;
      hold_ch_q <= 1'b0;
      chan_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      res_q     <= res_d;
      acc_q     <= acc_d;
      sent_q    <= sent_d;
      hold_w_q  <= hold_w_d;
      hold_v_q  <= hold_v_d;
      hold_ch_q <= hold_ch_d;
      chan_q    <= chan_d;
      err_q     <= err_d;
    end
  end

  // Valids are withdrawn in the same cycle the PE raises backpressure.
  assign bus.BUSY     = (state_q != IDLE);
  assign bus.DONE     = (state_q == FIN);
  assign bus.ERR_Q2   = err_q;
  assign bus.H_READY  = h_ready;
  assign bus.D        = hold_w_q;
  assign bus.D2       = hold_w_q;
  assign bus.D_VALID  = hold_v_q & ~hold_ch_q & ~bus.D_BP;
  assign bus.D2_VALID = hold_v_q &  hold_ch_q & ~bus.D2_BP;
  assign bus.Q_BP     = (fifo_cnt >= FCNT_W'(OFIFO_DEPTH - 1));
  assign bus.Q2_BP    = 1'b0;
  assign bus.R_VALID  = ~fifo_empty;

endmodule

// File: tb/tb_pe_stream_driver.sv
// Self-checking bench for pe_stream_driver: a behavioural host, a queue-based
// PE (Q = D + D2 after a fixed delay, honouring Q_BP) and a result-buffer
// occupancy model.
module tb_pe_stream_driver;

  localparam int unsigned LEN_W       = 32;
  localparam int unsigned OFIFO_DEPTH = 4;
  localparam logic [63:0] NO_WORD     = 64'hBAD0_BAD0_BAD0_BAD0;

  logic CLK = 1'b0;
  logic SYS_RST = 1'b1;
  always #5 CLK = ~CLK;

  pe_stream_driver_if #(.LEN_W(LEN_W)) bus ();

  pe_stream_driver #(
    .LEN_W       (LEN_W),
    .OFIFO_DEPTH (OFIFO_DEPTH)
  ) dut (
    .CLK     (CLK),
    .SYS_RST (SYS_RST),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // host / model state
  logic [63:0] hw [0:63];
  int          host_idx = 0, host_n = 0;
  bit          host_en = 0, gap_en = 0;
  logic [63:0] exp_d[$], exp_d2[$], exp_r[$];
  logic [63:0] pe_a[$], pe_b[$], pe_pend[$];
  int          pe_rdy[$];
  int          cyc = 0, occ = 0;
  int          done_cnt, rd_cnt, busy_cyc, hr_cnt, dv_cnt, job_n;
  int          first_send, last_send;
  bit          qbp_seen, busy_fall_pend;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_reset(input string t);
    chk({t, "_busy"},    64'(bus.BUSY),     64'd0);
    chk({t, "_done"},    64'(bus.DONE),     64'd0);
    chk({t, "_hready"},  64'(bus.H_READY),  64'd0);
    chk({t, "_dvalid"},  64'(bus.D_VALID),  64'd0);
    chk({t, "_d2valid"}, 64'(bus.D2_VALID), 64'd0);
    chk({t, "_rvalid"},  64'(bus.R_VALID),  64'd0);
    chk({t, "_err"},     64'(bus.ERR_Q2),   64'd0);
    chk({t, "_qbp"},     64'(bus.Q_BP),     64'd0);
    chk({t, "_d"},       bus.D,             64'd0);
    chk({t, "_d2"},      bus.D2,            64'd0);
  endtask

  task automatic clear_model();
    exp_d.delete(); exp_d2.delete(); exp_r.delete();
    pe_a.delete(); pe_b.delete(); pe_pend.delete(); pe_rdy.delete();
    occ = 0; host_en = 0; host_idx = 0; host_n = 0;
  endtask

  // Build host word list and the expected D / D2 / result streams.
  task automatic setup_seq(input int n, input bit rnd);
    host_n = 2 * n;
    host_idx = 0;
    for (int i = 0; i < 2 * n; i++) begin
      hw[i] = rnd ? {$urandom(), $urandom()} : 64'(i + 1);
      if (i % 2 == 0) exp_d.push_back(hw[i]);
      else            exp_d2.push_back(hw[i]);
    end
    for (int i = 0; i < n; i++) exp_r.push_back(hw[2*i] + hw[2*i+1]);
    host_en = 1;
  endtask

  // mode 0: quiet, 1: D_BP for cycles 2..6, 2: R_READY low 20 cycles, 3: random
  task automatic run_job(input int n, input int mode, input int budget);
    int k;
    done_cnt = 0; rd_cnt = 0; busy_cyc = 0; hr_cnt = 0; dv_cnt = 0;
    qbp_seen = 0; first_send = -1; last_send = -1; job_n = n;
    bus.LEN = LEN_W'(n);
    bus.START = 1'b1;
    @(posedge CLK); #1;
    bus.START = 1'b0;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      case (mode)
        1: bus.D_BP = (k >= 2 && k <= 6);
        2: bus.R_READY = (k >= 20);
        3: begin
          bus.D_BP    = ($urandom_range(0, 3) == 0);
          bus.D2_BP   = ($urandom_range(0, 3) == 0);
          bus.R_READY = ($urandom_range(0, 2) != 0);
        end
        default: ;
      endcase
      @(posedge CLK); #1;
      k++;
    end
    chk("done_seen", 64'(done_cnt), 64'd1);
    bus.D_BP = 1'b0; bus.D2_BP = 1'b0; bus.R_READY = 1'b1;
    @(posedge CLK); #1;
    chk("done_once", 64'(done_cnt), 64'd1);
    chk("exp_d_left",  64'(exp_d.size()),  64'd0);
    chk("exp_d2_left", 64'(exp_d2.size()), 64'd0);
    chk("exp_r_left",  64'(exp_r.size()),  64'd0);
    host_en = 0;
  endtask

  // Monitor / scoreboard: samples mid-cycle, ahead of the capturing edge.
  always @(negedge CLK) begin
    logic [63:0] e;
    cyc++;
    if (!SYS_RST) begin
      chk("q2_bp", 64'(bus.Q2_BP), 64'd0);
      if (bus.D_BP)  chk("dvalid_under_bp",  64'(bus.D_VALID),  64'd0);
      if (bus.D2_BP) chk("d2valid_under_bp", 64'(bus.D2_VALID), 64'd0);
      chk("q_bp_vs_occ",    64'(bus.Q_BP),    64'(occ >= OFIFO_DEPTH - 1));
      chk("r_valid_vs_occ", 64'(bus.R_VALID), 64'(occ != 0));
      if (busy_fall_pend) begin
        chk("busy_after_done", 64'(bus.BUSY), 64'd0);
        busy_fall_pend = 0;
      end
      if (bus.BUSY)    busy_cyc++;
      if (bus.H_READY) hr_cnt++;
      if (bus.Q_BP)    qbp_seen = 1;
      if (bus.DONE) begin
        done_cnt++;
        chk("busy_at_done",  64'(bus.BUSY), 64'd1);
        chk("reads_at_done", 64'(rd_cnt),   64'(job_n));
        busy_fall_pend = 1;
      end
      if (bus.H_VALID && bus.H_READY) host_idx++;
      if (bus.D_VALID) begin
        dv_cnt++;
        if (first_send < 0) first_send = cyc;
        last_send = cyc;
        if (exp_d.size() != 0) e = exp_d.pop_front(); else e = NO_WORD;
        chk("d_word", bus.D, e);
        pe_a.push_back(bus.D);
      end
      if (bus.D2_VALID) begin
        if (first_send < 0) first_send = cyc;
        last_send = cyc;
        if (exp_d2.size() != 0) e = exp_d2.pop_front(); else e = NO_WORD;
        chk("d2_word", bus.D2, e);
        pe_b.push_back(bus.D2);
      end
      while (pe_a.size() != 0 && pe_b.size() != 0) begin
        pe_pend.push_back(pe_a.pop_front() + pe_b.pop_front());
        pe_rdy.push_back(cyc + 2);
      end
      if (bus.Q_VALID) begin
        void'(pe_pend.pop_front());
        void'(pe_rdy.pop_front());
        occ++;
      end
      if (bus.R_VALID && bus.R_READY) begin
        rd_cnt++;
        if (exp_r.size() != 0) e = exp_r.pop_front(); else e = NO_WORD;
        chk("r_data", bus.R_D, e);
        occ--;
      end
    end
  end

  // Host operand source and PE result source.
  always @(posedge CLK) begin
    #2;
    if (!SYS_RST && host_en && host_idx < host_n && (!gap_en || $urandom_range(0, 3) != 0)) begin
      bus.H_VALID = 1'b1;
      bus.H_D     = hw[host_idx];
    end else begin
      bus.H_VALID = 1'b0;
      bus.H_D     = '0;
    end
    if (!SYS_RST && pe_pend.size() != 0 && pe_rdy[0] <= cyc && !bus.Q_BP) begin
      bus.Q_VALID = 1'b1;
      bus.Q       = pe_pend[0];
    end else begin
      bus.Q_VALID = 1'b0;
      bus.Q       = '0;
    end
  end

  initial begin
    int k;
    bus.START = 1'b0; bus.LEN = '0; bus.D_BP = 1'b0; bus.D2_BP = 1'b0;
    bus.Q2 = '0; bus.Q2_VALID = 1'b0; bus.R_READY = 1'b1;
    bus.H_VALID = 1'b0; bus.H_D = '0; bus.Q_VALID = 1'b0; bus.Q = '0;
    busy_fall_pend = 0;
    repeat (3) @(posedge CLK);
    #1 SYS_RST = 1'b0;
    @(negedge CLK);
    check_reset("por");
    @(posedge CLK); #1;

    // basic job, full throughput
    setup_seq(4, 0);
    run_job(4, 0, 200);
    chk("t1_send_span", 64'(last_send - first_send), 64'd7);

    // D backpressure window
    setup_seq(4, 0);
    run_job(4, 1, 200);

    // host stalls results; buffer fills and Q_BP engages
    setup_seq(8, 0);
    run_job(8, 2, 400);
    chk("t3_qbp_seen", 64'(qbp_seen), 64'd1);

    // zero-length job
    setup_seq(0, 0);
    run_job(0, 0, 20);
    chk("t4_busy_cycles", 64'(busy_cyc), 64'd1);
    chk("t4_hready_cnt",  64'(hr_cnt),   64'd0);
    chk("t4_dvalid_cnt",  64'(dv_cnt),   64'd0);

    // reset in the middle of a job, then a fresh job
    setup_seq(4, 0);
    job_n = 4;
    bus.LEN = LEN_W'(4);
    bus.START = 1'b1;
    @(posedge CLK); #1;
    bus.START = 1'b0;
    k = 0;
    while (host_idx < 3 && k < 50) begin
      @(posedge CLK); #1;
      k++;
    end
    chk("t5_three_words", 64'(host_idx >= 3), 64'd1);
    SYS_RST = 1'b1;
    clear_model();
    busy_fall_pend = 0;
    @(posedge CLK); #1;
    SYS_RST = 1'b0;
    @(negedge CLK);
    check_reset("mid");
    @(posedge CLK); #1;
    setup_seq(2, 0);
    run_job(2, 0, 200);

    // Q2_VALID sets a sticky error, cleared by the next START
    bus.Q2_VALID = 1'b1;
    @(posedge CLK); #1;
    bus.Q2_VALID = 1'b0;
    @(negedge CLK);
    chk("t6_err_set", 64'(bus.ERR_Q2), 64'd1);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk("t6_err_sticky", 64'(bus.ERR_Q2), 64'd1);
    @(posedge CLK); #1;
    setup_seq(1, 1);
    run_job(1, 0, 200);
    chk("t6_err_cleared", 64'(bus.ERR_Q2), 64'd0);

    // randomized jobs: random data, gaps, backpressure and host readiness
    gap_en = 1;
    for (int r = 0; r < 6; r++) begin
      k = $urandom_range(1, 8);
      setup_seq(k, 1);
      run_job(k, 3, 3000);
    end
    gap_en = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
